ldm_stm_sequencer: RTL and testbench

//  Multi-register transfer controller for LDM/STM. Owns the register-file ports for the

---
 rtl/ldm_stm_sequencer_if.sv | 46 ++++
 rtl/ldm_stm_sequencer.sv | 116 +++++++++++
 tb/tb_ldm_stm_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Handshake/bus bundle for the LDM/STM sequencer: command from decode,
// data-memory beat port and register-file read/write ports.
interface ldm_stm_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // command side
    logic              start;
    logic [15:0]       reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        base_reg;
    logic              is_load;
    logic              up;
    logic              pre;
    logic              writeback;
    // memory side
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    // register-file side
    logic [3:0]        rf_r_addr;
    logic [3:0]        rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              rf_w_en;
    // status
    logic              busy;
    logic              done;

    // sequencer side: owns the memory beat and the regfile ports
    modport master (
        input  start, reg_list, base_addr, base_reg, is_load, up, pre, writeback,
        input  mem_ready, mem_rdata,
        output mem_addr, mem_rd, mem_wr, rf_r_addr, rf_w_addr, rf_w_data, rf_w_en,
        output busy, done
    );

    // environment side: decode/execute, memory and register file
    modport slave (
        output start, reg_list, base_addr, base_reg, is_load, up, pre, writeback,
        output mem_ready, mem_rdata,
        input  mem_addr, mem_rd, mem_wr, rf_r_addr, rf_w_addr, rf_w_data, rf_w_en,
        input  busy, done
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer. Walks the register list lowest register
// first at ascending word addresses, one register per memory beat, then
// optionally writes the updated base back to Rn.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ldm_stm_sequencer_if.master  bus
);

    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    // command fields held for the whole transfer
    typedef struct packed {
        logic [3:0]        base_reg;
        logic              is_load;
        logic              do_wb;
        logic [ADDR_W-1:0] wb_val;
    } cmd_t;

    state_t            state;
    cmd_t              cmd;
    logic [15:0]       mask_q;
    logic [ADDR_W-1:0] addr_q;

    logic [4:0]        n_regs;
    logic [ADDR_W-1:0] four_n;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_val;
    logic [3:0]        cur;
    logic [15:0]       mask_next;
    logic              in_xfer;
    logic              in_wb;
    logic              ld_beat;

    // number of registers in the incoming list
    always_comb begin
        n_regs = '0;
        for (int i = 0; i < 16; i++)
            n_regs = n_regs + 5'(bus.reg_list[i]);
    end

    assign four_n = ADDR_W'({n_regs, 2'b00});
    assign wb_val = bus.up ? bus.base_addr + four_n : bus.base_addr - four_n;

    // lowest word address of the block; the walk always ascends from here
    always_comb begin
        case ({bus.up, bus.pre})
            2'b10:   start_addr = bus.base_addr;
            2'b11:   start_addr = bus.base_addr + ADDR_W'(4);
            2'b00:   start_addr = bus.base_addr - four_n + ADDR_W'(4);
            default: start_addr = bus.base_addr - four_n;
        endcase
    end

    // current register: lowest set bit still pending
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--)
            if (mask_q[i]) cur = 4'(i);
    end

    // clearing the lowest set bit retires the current register
    assign mask_next = mask_q & (mask_q - 16'd1);

    // transfer state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cmd    <= '0;
            mask_q <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cmd.base_reg <= bus.base_reg;
                    cmd.is_load  <= bus.is_load;
                    // a loaded base value takes priority over writeback
                    cmd.do_wb    <= bus.writeback &&
                                    !(bus.is_load && bus.reg_list[bus.base_reg]);
                    cmd.wb_val   <= wb_val;
                    mask_q       <= bus.reg_list;
                    addr_q       <= start_addr;
                    state        <= (bus.reg_list == '0) ? DONE : XFER;
                end
                XFER: if (bus.mem_ready) begin
                    mask_q <= mask_next;
                    addr_q <= addr_q + ADDR_W'(4);
                    if (mask_next == '0)
                        state <= cmd.do_wb ? WB : DONE;
                end
                WB:      state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_xfer = (state == XFER);
    assign in_wb   = (state == WB);
    assign ld_beat = in_xfer && cmd.is_load;

    // port drive: everything is forced low outside XFER/WB so a reset or
    // idle sequencer never leaves a strobe or stale address on the buses
    assign bus.mem_addr  = in_xfer ? addr_q : '0;
    assign bus.mem_rd    = ld_beat;
    assign bus.mem_wr    = in_xfer && !cmd.is_load;
    assign bus.rf_r_addr = in_xfer ? cur : '0;
    assign bus.rf_w_en   = (ld_beat && bus.mem_ready) || in_wb;
    assign bus.rf_w_addr = in_wb ? cmd.base_reg : (ld_beat ? cur : '0);
    assign bus.rf_w_data = in_wb ? DATA_W'(cmd.wb_val) : (ld_beat ? bus.mem_rdata : '0);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: a table of transfers with hand-derived start
// address, writeback value and latency; per-beat expectations go through a
// scoreboard queue and are popped as the DUT completes beats.
module tb_ldm_stm_sequencer;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    ldm_stm_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  breg;
        logic        ld, up, pre, wb;
        int          stall_beat;
        int          stall_n;
        bit          poke;
        logic [31:0] exp_first;
        logic        exp_wb;
        logic [31:0] exp_wbv;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          kind;   // 0 load beat, 1 store beat, 2 writeback
        logic [3:0]  rg;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t  exp_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(string nm, logic [15:0] list, logic [31:0] base,
                                 logic [3:0] breg, logic ld, logic up, logic pre,
                                 logic wb, int sb, int sn, bit poke,
                                 logic [31:0] first, logic ewb, logic [31:0] wbv, int lat);
        vec_t v;
        v.name = nm; v.list = list; v.base = base; v.breg = breg;
        v.ld = ld; v.up = up; v.pre = pre; v.wb = wb;
        v.stall_beat = sb; v.stall_n = sn; v.poke = poke;
        v.exp_first = first; v.exp_wb = ewb; v.exp_wbv = wbv; v.exp_lat = lat;
        return v;
    endfunction

    task automatic drive_cmd(input vec_t v);
        bus.reg_list  = v.list;
        bus.base_addr = v.base;
        bus.base_reg  = v.breg;
        bus.is_load   = v.ld;
        bus.up        = v.up;
        bus.pre       = v.pre;
        bus.writeback = v.wb;
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc, beat, stall_left, k;
        bit          fin;
        logic [31:0] rd_val;
        ev_t         e;
        @(posedge clk); #1;
        drive_cmd(v);
        bus.start     = 1;
        bus.mem_ready = 1;
        k = 0;
        for (int i = 0; i < 16; i++)
            if (v.list[i]) begin
                e.kind = v.ld ? 0 : 1; e.rg = 4'(i);
                e.addr = v.exp_first + 32'(4 * k); e.data = '0;
                exp_q.push_back(e);
                k++;
            end
        if (v.exp_wb) begin
            e.kind = 2; e.rg = v.breg; e.addr = '0; e.data = v.exp_wbv;
            exp_q.push_back(e);
        end
        cyc = 0; beat = 0; stall_left = v.stall_n; fin = 0;
        while (!fin) begin
            @(posedge clk); cyc++; #1;
            bus.start = 0;
            if (v.poke && cyc == 1) begin
                bus.start     = 1;
                bus.reg_list  = 16'hFFFF;
                bus.base_addr = 32'hDEAD_0000;
                bus.is_load   = ~v.ld;
                bus.writeback = 1;
            end
            rd_val        = $urandom;
            bus.mem_rdata = rd_val;
            bus.mem_ready = 1;
            if ((bus.mem_rd || bus.mem_wr) && beat == v.stall_beat && stall_left > 0) begin
                bus.mem_ready = 0;
                stall_left--;
            end
            @(negedge clk);
            chk({v.name, "_rdwr_excl"}, 32'(bus.mem_rd & bus.mem_wr), 0);
            if ((bus.mem_rd || bus.mem_wr) && bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk({v.name, "_extra_beat"}, 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk({v.name, "_kind"}, bus.mem_rd ? 0 : 1, e.kind);
                    chk({v.name, "_addr"}, bus.mem_addr, e.addr);
                    if (bus.mem_rd) begin
                        chk({v.name, "_wen"},   32'(bus.rf_w_en), 1);
                        chk({v.name, "_waddr"}, 32'(bus.rf_w_addr), 32'(e.rg));
                        chk({v.name, "_wdata"}, bus.rf_w_data, rd_val);
                    end else begin
                        chk({v.name, "_raddr"}, 32'(bus.rf_r_addr), 32'(e.rg));
                        chk({v.name, "_st_wen"}, 32'(bus.rf_w_en), 0);
                    end
                end
                beat++;
            end else if (bus.mem_rd || bus.mem_wr) begin
                chk({v.name, "_stall_wen"}, 32'(bus.rf_w_en), 0);
                if (exp_q.size() > 0) begin
                    chk({v.name, "_stall_addr"}, bus.mem_addr, exp_q[0].addr);
                    if (bus.mem_rd)
                        chk({v.name, "_stall_waddr"}, 32'(bus.rf_w_addr), 32'(exp_q[0].rg));
                end
            end else if (bus.rf_w_en) begin
                if (exp_q.size() == 0) begin
                    chk({v.name, "_extra_wen"}, 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk({v.name, "_wb_kind"},  2, e.kind);
                    chk({v.name, "_wb_addr"},  32'(bus.rf_w_addr), 32'(e.rg));
                    chk({v.name, "_wb_data"},  bus.rf_w_data, e.data);
                end
            end
            if (bus.done) begin
                chk({v.name, "_latency"}, cyc, v.exp_lat);
                fin = 1;
            end else if (cyc > 60) begin
                chk({v.name, "_timeout_cycles"}, cyc, v.exp_lat);
                fin = 1;
            end
        end
        chk({v.name, "_leftover"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"},   32'(bus.busy), 0);
        chk({nm, "_done"},   32'(bus.done), 0);
        chk({nm, "_strobe"}, {29'd0, bus.mem_rd, bus.mem_wr, bus.rf_w_en}, 0);
        chk({nm, "_maddr"},  bus.mem_addr, 0);
        chk({nm, "_wdata"},  bus.rf_w_data, 0);
        chk({nm, "_regs"},   {24'd0, bus.rf_r_addr, bus.rf_w_addr}, 0);
    endtask

    initial begin
        vec_t v;
        //            name      list      base          breg ld up pr wb  sb sn poke first         ewb wbv           lat
        vecs[0] = mkv("ldmia",  16'h0005, 32'h100,      0,   1, 1, 0, 0, -1, 0, 0, 32'h100,      0, 32'h0,        3);
        vecs[1] = mkv("stmdb",  16'h400A, 32'h200,      13,  0, 0, 1, 1, -1, 0, 0, 32'h1F4,      1, 32'h1F4,      5);
        vecs[2] = mkv("ldmib",  16'h0003, 32'h1000,     0,   1, 1, 1, 0,  1, 3, 0, 32'h1004,     0, 32'h0,        6);
        vecs[3] = mkv("empty",  16'h0000, 32'h300,      3,   1, 1, 0, 1, -1, 0, 0, 32'h300,      0, 32'h0,        1);
        vecs[4] = mkv("ldbase", 16'h0006, 32'h40,       2,   1, 1, 0, 1, -1, 0, 0, 32'h40,       0, 32'h0,        3);
        vecs[5] = mkv("ldmda",  16'h0007, 32'h4,        0,   1, 0, 0, 0, -1, 0, 0, 32'hFFFFFFFC, 0, 32'h0,        4);
        vecs[6] = mkv("stmia",  16'h8001, 32'h80,       0,   0, 1, 0, 1, -1, 0, 0, 32'h80,       1, 32'h88,       4);
        vecs[7] = mkv("stmib",  16'h0030, 32'hFFFFFFF8, 5,   0, 1, 1, 1, -1, 0, 0, 32'hFFFFFFFC, 1, 32'h0,        4);
        vecs[8] = mkv("ldmdbf", 16'hFFFF, 32'h1000,     15,  1, 0, 1, 1, -1, 0, 0, 32'hFC0,      0, 32'h0,       17);

        bus.start = 0; bus.reg_list = '0; bus.base_addr = '0; bus.base_reg = '0;
        bus.is_load = 0; bus.up = 0; bus.pre = 0; bus.writeback = 0;
        bus.mem_ready = 0; bus.mem_rdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1 rst = 0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start pulsed while busy must not disturb the latched transfer
        v = mkv("poke", 16'h0003, 32'h500, 0, 1, 1, 0, 0, -1, 0, 1, 32'h500, 0, 32'h0, 3);
        run_vec(v);

        // reset during the second beat of an LDMIA
        v = mkv("rstmid", 16'h0007, 32'h600, 0, 1, 1, 0, 0, -1, 0, 0, 32'h600, 0, 32'h0, 4);
        @(posedge clk); #1;
        drive_cmd(v);
        bus.start = 1; bus.mem_ready = 1;
        @(posedge clk); #1 bus.start = 0;
        @(posedge clk); #1;
        rst = 1; bus.mem_ready = 0;
        @(negedge clk);
        chk("rstmid_beat2_rd",   32'(bus.mem_rd), 1);
        chk("rstmid_beat2_addr", bus.mem_addr, 32'h604);
        @(posedge clk); #1;
        rst = 0; bus.mem_ready = 1;
        @(negedge clk);
        chk_quiet("rstmid_after");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_quiet", {28'd0, bus.busy, bus.mem_rd, bus.mem_wr, bus.rf_w_en}, 0);
        end

        // sequencer still usable after the aborted transfer
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
